// File: rtl/uart_rx.sv
// 8N1 UART receiver for the FTDI channel-B line: two-flop synchroniser,
// mid-bit sampling FSM and a one-deep holding register with valid/ack handshake.
module uart_rx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int DATA_BITS    = 8
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_rx,
  input  logic       i_ack,
  output logic [7:0] o_data,
  output logic       o_valid,
  output logic       o_frame_err,
  output logic       o_overrun,
  output logic       o_busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [2:0]       IDX_LAST = 3'(DATA_BITS - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_STOP  = 3'd3;
  localparam logic [2:0] S_BREAK = 3'd4;

  logic             rx_meta_q, rx_meta_d;
  logic             rx_s_q, rx_s_d;
  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             deliver_q, deliver_d;
  logic             frame_err_q, frame_err_d;
  logic             overrun_q, overrun_d;
  logic             valid_q, valid_d;
  logic [7:0]       data_q, data_d;

  assign rx_meta_d = i_rx;
  assign rx_s_d    = rx_meta_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    shift_d     = shift_q;
    deliver_d   = 1'b0;
    frame_err_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!rx_s_q) begin
          state_d = S_START;
          cnt_d   = '0;
        end
      end
      // A start bit that is no longer low at its midpoint is treated as a glitch.
      S_START: begin
        if (cnt_q == CNT_HALF) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = rx_s_q ? S_IDLE : S_DATA;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          shift_d = {rx_s_q, shift_q[7:1]};
          idx_d   = idx_q + 3'd1;
          if (idx_q == IDX_LAST) begin
            state_d = S_STOP;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      // Leaving mid-stop-bit lets a following start edge be caught immediately.
      S_STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (rx_s_q) begin
            deliver_d = 1'b1;
            state_d   = S_IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = S_BREAK;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_BREAK: begin
        if (rx_s_q) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        idx_d   = '0;
      end
    endcase
  end

  // shift_q cannot change for at least half a bit after delivery, so the
  // holding register can load it one edge later without an extra copy.
  always_comb begin
    valid_d   = valid_q;
    data_d    = data_q;
    overrun_d = 1'b0;
    if (valid_q && i_ack) begin
      valid_d = 1'b0;
    end
    if (deliver_q) begin
      if (!valid_q || i_ack) begin
        data_d  = shift_q;
        valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      rx_meta_q   <= 1'b1;
      rx_s_q      <= 1'b1;
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      shift_q     <= '0;
      deliver_q   <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      valid_q     <= 1'b0;
      data_q      <= '0;
    end else begin
      rx_meta_q   <= rx_meta_d;
      rx_s_q      <= rx_s_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      shift_q     <= shift_d;
      deliver_q   <= deliver_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
      valid_q     <= valid_d;
      data_q      <= data_d;
    end
  end

  assign o_data      = data_q;
  assign o_valid     = valid_q;
  assign o_frame_err = frame_err_q;
  assign o_overrun   = overrun_q;
  assign o_busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed frames plus random bytes, checked
// against a byte-level model of the holding register and flag counts.
module tb_uart_rx;

  localparam int CPB = 16;

  logic       clk;
  logic       rst_n;
  logic       rx;
  logic       ack;
  logic [7:0] o_data;
  logic       o_valid;
  logic       o_frame_err;
  logic       o_overrun;
  logic       o_busy;

  int checks   = 0;
  int failures = 0;

  int         valid_cycles = 0;
  int         ovr_cnt      = 0;
  int         fe_cnt       = 0;
  int         both_cnt     = 0;
  logic [7:0] seen_data    = 8'h00;

  logic       exp_valid = 1'b0;
  logic [7:0] exp_data  = 8'h00;
  int         exp_ovr   = 0;
  int         exp_fe    = 0;

  uart_rx #(.CLKS_PER_BIT(CPB), .DATA_BITS(8)) dut (
    .i_clk       (clk),
    .i_reset     (rst_n),
    .i_rx        (rx),
    .i_ack       (ack),
    .o_data      (o_data),
    .o_valid     (o_valid),
    .o_frame_err (o_frame_err),
    .o_overrun   (o_overrun),
    .o_busy      (o_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Flag and delivery observations, sampled on the inactive edge.
  always @(negedge clk) begin
    if (o_valid) begin
      valid_cycles <= valid_cycles + 1;
      seen_data    <= o_data;
    end
    if (o_overrun)   ovr_cnt <= ovr_cnt + 1;
    if (o_frame_err) fe_cnt  <= fe_cnt + 1;
    if (o_overrun && o_frame_err) both_cnt <= both_cnt + 1;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Drives one 8N1 frame, LSB first, leaving the line at the stop-bit level.
  task automatic applyStimulus(input logic [7:0] b, input logic stop_bit);
    rx = 1'b0;
    repeat (CPB) tick();
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) tick();
    end
    rx = stop_bit;
    repeat (CPB) tick();
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic modelDeliver(input logic [7:0] b, input logic ack_now);
    if (!exp_valid || ack_now) begin
      exp_data  = b;
      exp_valid = 1'b1;
    end else begin
      exp_ovr++;
    end
  endtask

  task automatic ackPulse;
    ack = 1'b1;
    tick();
    ack = 1'b0;
    tick();
    exp_valid = 1'b0;
  endtask

  task automatic checkModel(input string tag);
    checkOutput({tag, "_data"},    {24'h0, o_data}, {24'h0, exp_data});
    checkOutput({tag, "_valid"},   {31'h0, o_valid}, {31'h0, exp_valid});
    checkOutput({tag, "_overrun"}, ovr_cnt, exp_ovr);
    checkOutput({tag, "_frmerr"},  fe_cnt, exp_fe);
  endtask

  initial begin
    logic [7:0] rb;
    int         gap;
    int         v0;

    rst_n = 1'b0;
    rx    = 1'b1;
    ack   = 1'b0;
    #3;
    checkOutput("reset_data",    {24'h0, o_data}, 32'h0);
    checkOutput("reset_valid",   {31'h0, o_valid}, 32'h0);
    checkOutput("reset_frmerr",  {31'h0, o_frame_err}, 32'h0);
    checkOutput("reset_overrun", {31'h0, o_overrun}, 32'h0);
    checkOutput("reset_busy",    {31'h0, o_busy}, 32'h0);
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (5) tick();

    $display("[TB] 0x55 with ack tied high");
    ack = 1'b1;
    v0  = valid_cycles;
    fork
      applyStimulus(8'h55, 1'b1);
      begin
        tick();
        checkOutput("t1_busy_before", {31'h0, o_busy}, 32'h0);
        repeat (79) tick();
        checkOutput("t1_busy_mid", {31'h0, o_busy}, 32'h1);
        repeat (78) tick();
        checkOutput("t1_busy_after_stop", {31'h0, o_busy}, 32'h0);
      end
    join
    repeat (4) tick();
    ack = 1'b0;
    checkOutput("t1_valid_cycles", valid_cycles - v0, 32'd1);
    checkOutput("t1_seen_data", {24'h0, seen_data}, 32'h55);
    exp_data  = 8'h55;
    exp_valid = 1'b0;
    checkModel("t1");

    $display("[TB] back-to-back 0xA3, 0x0F without ack");
    applyStimulus(8'hA3, 1'b1);
    applyStimulus(8'h0F, 1'b1);
    repeat (4) tick();
    modelDeliver(8'hA3, 1'b0);
    modelDeliver(8'h0F, 1'b0);
    checkModel("t2");
    ackPulse();
    checkModel("t2_acked");

    $display("[TB] short low glitch on idle line");
    rx = 1'b0;
    repeat (5) tick();
    checkOutput("t3_busy_glitch", {31'h0, o_busy}, 32'h1);
    tick();
    rx = 1'b1;
    repeat (30) tick();
    checkOutput("t3_busy_after", {31'h0, o_busy}, 32'h0);
    checkModel("t3");

    $display("[TB] framing error then break");
    applyStimulus(8'h3C, 1'b0);
    repeat (40) tick();
    exp_fe++;
    checkOutput("t4_busy_break", {31'h0, o_busy}, 32'h1);
    checkModel("t4_err");
    rx = 1'b1;
    tick();
    checkOutput("t4_busy_release1", {31'h0, o_busy}, 32'h1);
    repeat (4) tick();
    checkOutput("t4_busy_release5", {31'h0, o_busy}, 32'h0);
    repeat (5) tick();
    applyStimulus(8'h81, 1'b1);
    repeat (4) tick();
    modelDeliver(8'h81, 1'b0);
    checkModel("t4_next");

    $display("[TB] reset during data bit 4");
    fork
      applyStimulus(8'hFF, 1'b1);
      begin
        repeat (88) tick();
        rst_n = 1'b0;
        tick();
        checkOutput("t5_rst_valid", {31'h0, o_valid}, 32'h0);
        checkOutput("t5_rst_data",  {24'h0, o_data}, 32'h0);
        checkOutput("t5_rst_busy",  {31'h0, o_busy}, 32'h0);
        tick();
        tick();
        rst_n = 1'b1;
      end
    join
    exp_valid = 1'b0;
    exp_data  = 8'h00;
    repeat (5) tick();
    checkModel("t5_abort");
    applyStimulus(8'h12, 1'b1);
    repeat (4) tick();
    modelDeliver(8'h12, 1'b0);
    checkModel("t5_next");

    $display("[TB] delivery coinciding with ack");
    ackPulse();
    applyStimulus(8'h11, 1'b1);
    repeat (4) tick();
    modelDeliver(8'h11, 1'b0);
    checkModel("t6_old");
    // Stop sample lands 155 edges after the start edge; delivery on the next one.
    fork
      applyStimulus(8'h22, 1'b1);
      begin
        repeat (155) tick();
        ack = 1'b1;
        tick();
        ack = 1'b0;
      end
    join
    repeat (4) tick();
    modelDeliver(8'h22, 1'b1);
    checkModel("t6_new");

    $display("[TB] random frames");
    for (int n = 0; n < 8; n++) begin
      rb  = 8'($urandom);
      gap = $urandom_range(0, 6);
      if ($urandom_range(0, 1) == 1) ackPulse();
      repeat (gap) tick();
      applyStimulus(rb, 1'b1);
      repeat (4) tick();
      modelDeliver(rb, 1'b0);
      checkModel($sformatf("rand%0d", n));
    end

    checkOutput("flags_together", both_cnt, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- 8N1 asynchronous serial receiver for the FTDI channel-B UART.
- Input pin: BDBUS2, FSDO, FTDI to FPGA.
- Runs on CLK100M.
- Oversamples the line with a per-bit counter and recovers each byte.
- Presents each byte through a one-deep holding register with a valid/ack handshake. This is the receive counterpart of the transmit path driving BDBUS0.

Parameters:
CLKS_PER_BIT, 868, i_clk cycles per bit (100 MHz / 115200); legal range >= 4; counter width $clog2(CLKS_PER_BIT)
DATA_BITS, 8, data bits per frame, LSB first; fixed at 8 for this revision

Ports:
i_clk  in  1  system clock (CLK100M)
i_reset  in  1  asynchronous reset, active-low; all state clears while low
i_rx  in  1  raw serial line, idle high, asynchronous to i_clk
i_ack  in  1  consumer accepts o_data; sampled only while o_valid=1
o_data  out  8  last received byte, stable while o_valid=1
o_valid  out  1  holding register full
o_frame_err  out  1  one-cycle pulse: stop bit sampled low
o_overrun  out  1  one-cycle pulse: good byte discarded because holding register was full
o_busy  out  1  high while the FSM is not IDLE

Behaviour:
- Reset values:
  - o_data=0x00, o_valid=0, o_frame_err=0, o_overrun=0, o_busy=0.
  - Synchroniser flops=1, FSM=IDLE, bit counter=0, shift register=0.
- Synchroniser: two flops on i_rx. The FSM sees only the second flop (rx_s). Input-to-FSM latency is 2 cycles.
- FSM states: IDLE, START, DATA, STOP, BREAK.
- IDLE:
  - rx_s=0 -> START, cnt=0.
  - Otherwise stay.
- START:
  - cnt counts up. At cnt=CLKS_PER_BIT/2-1 (integer division), sample rx_s.
  - Sample 0 -> DATA, cnt=0, bit index=0.
  - Sample 1 -> IDLE. This is glitch rejection: no flags are raised.
- DATA:
  - At cnt=CLKS_PER_BIT-1, sample rx_s into shift register MSB, shift right (LSB first), cnt=0, index+1.
  - After the 8th sample -> STOP.
- STOP: at cnt=CLKS_PER_BIT-1, sample rx_s.
  - Sample 1, good frame: deliver the byte and go -> IDLE the same edge. Returning mid-stop-bit allows back-to-back frames.
  - Sample 0: o_frame_err pulses 1 cycle, byte discarded -> BREAK.
- BREAK: wait for rx_s=1, then -> IDLE. This prevents a held-low line or break from retriggering frames.
- Delivery: o_data/o_valid update on the edge after the stop sample edge. Total latency from the line's stop-bit midpoint is about 3 cycles.
- Handshake:
  - o_valid=1 and i_ack=1 -> o_valid=0 next edge; o_data holds its value.
  - Delivery while o_valid=0: o_data=byte, o_valid=1.
  - Delivery while o_valid=1 and i_ack=1 on the same cycle: new byte loaded, o_valid stays 1, no overrun.
  - Delivery while o_valid=1 and i_ack=0: byte dropped, o_data unchanged, o_overrun pulses 1 cycle.
- o_busy is 0 in IDLE and 1 in all other states. BREAK counts as busy.
- Reset mid-frame (i_reset low at any point): immediate return to reset values. After release, a low line is treated as a new start edge only after the synchroniser shows 0. No partial byte is ever delivered.
- Counter never exceeds CLKS_PER_BIT-1. There is no wrap beyond terminal count.
- Bit index is 3 bits plus an end condition. There are no off-by-one extra samples.
- Flags never assert together in one cycle.

Test Plan:
- CLKS_PER_BIT=16; send 0x55 8N1 with i_ack tied 1 -> o_valid pulses 1 cycle, o_data=0x55, no flags; o_busy high from start edge +2 until stop sample.
- Send 0xA3 then 0x0F back-to-back with no idle gap, i_ack=0 until both frames are done -> o_data=0xA3, o_valid=1, o_overrun pulses once at the second stop sample. Then i_ack=1 for 1 cycle -> o_valid=0, o_data still 0xA3.
- Low glitch of 6 cycles (< CLKS_PER_BIT/2) on idle line -> FSM returns to IDLE, no o_valid, no flags.
- Frame 0x3C with stop bit forced 0, line held low 40 cycles then high -> o_frame_err single pulse, o_valid stays 0, o_busy stays 1 until line high +2, then a following 0x81 frame is received correctly.
- Assert i_reset low for 3 cycles at DATA bit 4 of frame 0xFF, release, then send 0x12 -> no delivery of the aborted frame; o_data=0x12, o_valid=1.
- Delivery coinciding with i_ack=1 while o_valid=1 (old 0x11, new 0x22) -> o_valid stays 1, o_data=0x22, o_overrun=0.
